servo_pwm_array: RTL



---
 rtl/servo_pkg.sv | 19 +
 rtl/servo_pwm_ch.sv | 61 ++++++
 rtl/servo_pwm_array.sv | 89 ++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared defaults, pulse-width word type and the command clamp for the servo PWM array.
package servo_pkg;

  localparam int unsigned SERVO_MIN_US    = 1000;
  localparam int unsigned SERVO_MAX_US    = 2000;
  localparam int unsigned SERVO_MID_US    = (SERVO_MIN_US + SERVO_MAX_US) / 2;
  localparam int unsigned SERVO_PERIOD_US = 20000;

  typedef logic [10:0] servo_us_t;

  function automatic int unsigned servo_clamp(input int unsigned v,
                                              input int unsigned lo,
                                              input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: commanded target, frame-latched active width, optional slew step, pulse compare.
// SERVO_SLEW_LIMIT_EN limits the per-frame change of the active width to SLEW_US.
module servo_pwm_ch #(
  parameter int unsigned W       = 11,
  parameter int unsigned MID_US  = 1500,
  parameter int unsigned SLEW_US = 10,
  parameter int unsigned FCW     = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           wr_en_i,
  input  logic [W-1:0]   wr_us_i,
  input  logic           load_i,
  input  logic [FCW-1:0] frame_cnt_i,
  output logic           pwm_o,
  output logic [W-1:0]   active_o
);

  logic [W-1:0] target_q, target_d;
  logic [W-1:0] active_q, active_d;
  logic [W-1:0] next_us;
  logic         pwm_q, pwm_d;

`ifdef SERVO_SLEW_LIMIT_EN
  logic signed [W:0] diff;
  logic        [W:0] mag;
  logic        [W:0] step;

  // Widened to W+1 bits so the difference of two unsigned widths cannot wrap.
  always_comb begin
    diff    = $signed({1'b0, target_q}) - $signed({1'b0, active_q});
    mag     = diff[W] ? $unsigned(-diff) : $unsigned(diff);
    step    = (mag > (W+1)'(SLEW_US)) ? (W+1)'(SLEW_US) : mag;
    next_us = diff[W] ? (active_q - step[W-1:0]) : (active_q + step[W-1:0]);
  end
`else
  assign next_us = target_q;
`endif

  always_comb begin
    target_d = wr_en_i ? wr_us_i : target_q;
    active_d = load_i  ? next_us : active_q;
    pwm_d    = (32'(frame_cnt_i) < 32'(active_q));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      target_q <= W'(MID_US);
      active_q <= W'(MID_US);
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign active_o = active_q;

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel RC-servo PWM: shared us prescaler, frame counter, command decode, frame_start.
// Optional slew limiting per channel under SERVO_SLEW_LIMIT_EN (see servo_pwm_ch).
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned N_CH      = 3,
  parameter int unsigned W         = $bits(servo_us_t),
  parameter int unsigned PERIOD_US = SERVO_PERIOD_US,
  parameter int unsigned MIN_US    = SERVO_MIN_US,
  parameter int unsigned MAX_US    = SERVO_MAX_US,
  parameter int unsigned SLEW_US   = 10,
  localparam int unsigned CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CHW-1:0]    cmd_ch,
  input  logic [W-1:0]      cmd_us,
  output logic [N_CH-1:0]   pwm,
  output logic              frame_start,
  output logic [N_CH*W-1:0] active_us
);

  localparam int unsigned DIV    = CLK_HZ / 1_000_000;
  localparam int unsigned DW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FCW    = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int unsigned MID_US = (MIN_US + MAX_US) / 2;

  logic [DW-1:0]  div_q, div_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic           frame_start_q, frame_start_d;
  logic           us_tick;
  logic           boundary;
  logic           cmd_acc;
  logic [W-1:0]   cmd_clamped;

  // frame_start and pwm both lag the counter by one cycle, so the pulse that
  // starts a frame coincides with frame_start, including the first frame after reset.
  always_comb begin
    us_tick       = (div_q == DW'(DIV - 1));
    boundary      = us_tick && (frame_q == FCW'(PERIOD_US - 1));
    div_d         = us_tick ? '0 : div_q + DW'(1);
    frame_d       = frame_q;
    if (boundary) begin
      frame_d = '0;
    end else if (us_tick) begin
      frame_d = frame_q + FCW'(1);
    end
    frame_start_d = (div_q == '0) && (frame_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      frame_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      frame_q       <= frame_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cmd_ready   = !boundary;
  assign cmd_acc     = cmd_valid && cmd_ready;
  assign cmd_clamped = W'(servo_clamp(32'(cmd_us), MIN_US, MAX_US));
  assign frame_start = frame_start_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_pwm_ch #(
      .W       (W),
      .MID_US  (MID_US),
      .SLEW_US (SLEW_US),
      .FCW     (FCW)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .wr_en_i     (cmd_acc && (cmd_ch == CHW'(i))),
      .wr_us_i     (cmd_clamped),
      .load_i      (boundary),
      .frame_cnt_i (frame_q),
      .pwm_o       (pwm[i]),
      .active_o    (active_us[i*W +: W])
    );
  end

endmodule
